// File: rtl/csr_file.sv
// Machine-mode CSR file: request/response access port, 64-bit cycle and
// instret counters, and trap entry/return bookkeeping for mstatus/mepc/mcause/mtval.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    input  logic        instret_pulse,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] LOW2_MASK   = 32'hFFFF_FFFC;

    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [31:0] mie_reg_q, mie_reg_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic        accept;
    logic        rd_ok;
    logic [31:0] rd_val;
    logic [31:0] mstatus_rd;
    logic        wr_req;
    logic        illegal;
    logic        wr_en;
    logic [31:0] new_val;
    logic [63:0] mcycle_inc;
    logic [63:0] minstret_inc;

    assign mstatus_rd = {19'd0, 2'b11, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
    assign accept     = req_valid && (state_q == ST_IDLE);

    always_comb begin
        rd_ok  = 1'b1;
        rd_val = '0;
        case (req_addr)
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MIP: rd_val = '0;
            A_MHARTID:   rd_val = HART_ID;
            A_MISA:      rd_val = 32'h4000_0100;
            A_MSTATUS:   rd_val = mstatus_rd;
            A_MIE:       rd_val = mie_reg_q;
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MTVAL:     rd_val = mtval_q;
            A_MCYCLE:    rd_val = mcycle_q[31:0];
            A_MCYCLEH:   rd_val = mcycle_q[63:32];
            A_MINSTRET:  rd_val = minstret_q[31:0];
            A_MINSTRETH: rd_val = minstret_q[63:32];
            default:     rd_ok  = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it may target read-only space.
    always_comb begin
        wr_req  = (req_op == 2'b01) || ((req_op != 2'b00) && (req_wdata != '0));
        illegal = !rd_ok || (req_op == 2'b00) || (wr_req && (req_addr[11:10] == 2'b11));
        wr_en   = accept && wr_req && !illegal;
        case (req_op)
            2'b01:   new_val = req_wdata;
            2'b10:   new_val = rd_val | req_wdata;
            default: new_val = rd_val & ~req_wdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        st_mie_d      = st_mie_q;
        st_mpie_d     = st_mpie_q;
        mie_reg_d     = mie_reg_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        mcycle_inc    = mcycle_q + 64'd1;
        minstret_inc  = minstret_q + {63'd0, instret_pulse};
        mcycle_d      = mcycle_inc;
        minstret_d    = minstret_inc;

        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            rsp_rdata_d   = illegal ? '0 : rd_val;
            rsp_illegal_d = illegal;
        end

        // Writing one counter half replaces that half's increment; a low-half
        // write also swallows the carry into the high half.
        if (wr_en) begin
            case (req_addr)
                A_MSTATUS: begin
                    if (!trap_valid && !mret) begin
                        st_mie_d  = new_val[3];
                        st_mpie_d = new_val[7];
                    end
                end
                A_MIE:       mie_reg_d  = new_val;
                A_MTVEC:     mtvec_d    = new_val & LOW2_MASK;
                A_MSCRATCH:  mscratch_d = new_val;
                A_MEPC:      if (!trap_valid) mepc_d   = new_val & LOW2_MASK;
                A_MCAUSE:    if (!trap_valid) mcause_d = new_val;
                A_MTVAL:     if (!trap_valid) mtval_d  = new_val;
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
                A_MCYCLEH:   mcycle_d   = {new_val, mcycle_inc[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
                A_MINSTRETH: minstret_d = {new_val, minstret_inc[31:0]};
                default: ;
            endcase
        end

        if (trap_valid) begin
            mepc_d    = trap_pc & LOW2_MASK;
            mcause_d  = trap_cause;
            mtval_d   = trap_tval;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            st_mie_q      <= 1'b0;
            st_mpie_q     <= 1'b0;
            mie_reg_q     <= '0;
            mtvec_q       <= MTVEC_RESET & LOW2_MASK;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            st_mie_q      <= st_mie_d;
            st_mpie_q     <= st_mpie_d;
            mie_reg_q     <= mie_reg_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;
    assign trap_vector = mtvec_q;
    assign mepc_o      = mepc_q;
    assign mie_o       = st_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus a randomized run, all checked
// against a register-level reference model of the machine CSRs.
module tb_csr_file;

    localparam logic [31:0] HART  = 32'd7;
    localparam logic [31:0] TVEC  = 32'h0000_1003;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        instret_pulse;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret;
    logic [31:0] trap_vector;
    logic [31:0] mepc_o;
    logic        mie_o;

    int unsigned n_vec;
    int unsigned n_err;

    csr_file #(.HART_ID(HART), .MTVEC_RESET(TVEC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .instret_pulse(instret_pulse), .trap_valid(trap_valid), .trap_pc(trap_pc),
        .trap_cause(trap_cause), .trap_tval(trap_tval), .mret(mret),
        .trap_vector(trap_vector), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic        m_busy;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_ill;
    logic        m_st_mie, m_st_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    task automatic model_reset();
        m_busy = 0; m_rsp_rdata = 0; m_rsp_ill = 0;
        m_st_mie = 0; m_st_mpie = 0;
        m_mie_reg = 0; m_mtvec = TVEC & ~32'h3; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    task automatic model_read(input logic [11:0] a, output bit ok, output logic [31:0] v);
        ok = 1; v = 0;
        case (a)
            12'hF11, 12'hF12, 12'hF13, 12'h344: v = 0;
            12'hF14: v = HART;
            12'h301: v = 32'h4000_0100;
            12'h300: v = 32'h1800 + (32'(m_st_mpie) * 128) + (32'(m_st_mie) * 8);
            12'h304: v = m_mie_reg;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            default: ok = 0;
        endcase
    endtask

    task automatic model_edge(input logic v, input logic [11:0] a, input logic [1:0] op,
                              input logic [31:0] wd, input logic ip, input logic tv,
                              input logic [31:0] pc, input logic [31:0] cause,
                              input logic [31:0] tval, input logic mr);
        bit          ok, wen, ill;
        logic [31:0] rv, nv;
        logic [63:0] cyc_n, ins_n;
        logic        old_mie;
        cyc_n = m_cyc + 1;
        ins_n = m_ins + 64'(ip);
        old_mie = m_st_mie;
        if (v && !m_busy) begin
            model_read(a, ok, rv);
            wen = (op == 2'd1) || (op != 2'd0 && wd != 0);
            ill = !ok || op == 2'd0 || (wen && a >= 12'hC00);
            if (op == 2'd1)      nv = wd;
            else if (op == 2'd2) nv = rv | wd;
            else                 nv = rv & ~wd;
            m_rsp_rdata = ill ? 32'd0 : rv;
            m_rsp_ill   = ill;
            if (!ill && wen) begin
                case (a)
                    12'h300: if (!tv && !mr) begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
                    12'h304: m_mie_reg = nv;
                    12'h305: m_mtvec = nv & ~32'h3;
                    12'h340: m_mscratch = nv;
                    12'h341: if (!tv) m_mepc = nv & ~32'h3;
                    12'h342: if (!tv) m_mcause = nv;
                    12'h343: if (!tv) m_mtval = nv;
                    12'hB00: cyc_n = {m_cyc[63:32], nv};
                    12'hB80: cyc_n = {nv, m_cyc[31:0] + 32'd1};
                    12'hB02: ins_n = {m_ins[63:32], nv};
                    12'hB82: ins_n = {nv, m_ins[31:0] + 32'(ip)};
                    default: ;
                endcase
            end
            m_busy = 1;
        end else begin
            m_busy = 0;
        end
        if (tv) begin
            m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = tval;
            m_st_mpie = old_mie; m_st_mie = 0;
        end else if (mr) begin
            m_st_mie = m_st_mpie; m_st_mpie = 1;
        end
        m_cyc = cyc_n;
        m_ins = ins_n;
    endtask

    task automatic step(input logic v, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic ip, input logic tv,
                        input logic [31:0] pc, input logic [31:0] cause,
                        input logic [31:0] tval, input logic mr);
        @(negedge clk);
        req_valid = v; req_addr = a; req_op = op; req_wdata = wd;
        instret_pulse = ip; trap_valid = tv; trap_pc = pc;
        trap_cause = cause; trap_tval = tval; mret = mr;
        @(posedge clk);
        model_edge(v, a, op, wd, ip, tv, pc, cause, tval, mr);
        #1;
    endtask

    task automatic req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        step(1, a, op, wd, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 12'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_assert();
        req_valid = 0; req_addr = 0; req_op = 0; req_wdata = 0;
        instret_pulse = 0; trap_valid = 0; trap_pc = 0;
        trap_cause = 0; trap_tval = 0; mret = 0;
        rst_n = 0;
        model_reset();
    endtask

    task automatic reset_release();
        @(posedge clk);
        #3 rst_n = 1;
    endtask

    task automatic test_reset();
        #2 reset_assert();
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_vec++; if (rsp_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b expected 0", rsp_illegal); end
        n_vec++; if (trap_vector !== 32'h0000_1000) begin n_err++; $display("FAIL reset_tvec: got %h expected 00001000", trap_vector); end
        n_vec++; if (mepc_o !== 32'd0 || mie_o !== 1'b0) begin n_err++; $display("FAIL reset_mepc_mie: got %h/%b expected 0/0", mepc_o, mie_o); end
        reset_release();
    endtask

    task automatic test_rw_rs();
        req(12'h340, 2'd1, 32'hDEADBEEF);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_illegal !== 1'b0) begin
            n_err++; $display("FAIL rw_first: got v=%b d=%h i=%b expected v=1 d=0 i=0", rsp_valid, rsp_rdata, rsp_illegal); end
        idle();
        req(12'h340, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'hDEADBEEF || rsp_illegal !== 1'b0) begin
            n_err++; $display("FAIL rs_readback: got d=%h i=%b expected d=deadbeef i=0", rsp_rdata, rsp_illegal); end
        idle();
        req(12'h341, 2'd1, 32'hFFFF_FFFF); idle();
        req(12'h341, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL mepc_low_bits: got %h expected fffffffc", rsp_rdata); end
        idle();
        req(12'h300, 2'd1, 32'hFFFF_FFFF); idle();
        req(12'h300, 2'd3, 32'd0);
        n_vec++; if (rsp_rdata !== 32'h0000_1888) begin n_err++; $display("FAIL mstatus_mask: got %h expected 00001888", rsp_rdata); end
        idle();
        req(12'h300, 2'd3, 32'h0000_0088); idle();
        n_vec++; if (mie_o !== 1'b0) begin n_err++; $display("FAIL mstatus_clear: got %b expected 0", mie_o); end
    endtask

    task automatic test_illegal();
        req(12'hF14, 2'd1, 32'd5);
        n_vec++; if (rsp_illegal !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL ro_write: got d=%h i=%b expected d=0 i=1", rsp_rdata, rsp_illegal); end
        idle();
        req(12'hF14, 2'd2, 32'd0);
        n_vec++; if (rsp_illegal !== 1'b0 || rsp_rdata !== HART) begin
            n_err++; $display("FAIL hartid_read: got d=%h i=%b expected d=%h i=0", rsp_rdata, rsp_illegal, HART); end
        idle();
        req(12'h7C0, 2'd2, 32'd0);
        n_vec++; if (rsp_illegal !== 1'b1) begin n_err++; $display("FAIL unimpl_addr: got %b expected 1", rsp_illegal); end
        idle();
        req(12'h340, 2'd0, 32'h1111_2222);
        n_vec++; if (rsp_illegal !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL op00: got d=%h i=%b expected d=0 i=1", rsp_rdata, rsp_illegal); end
        idle();
        req(12'h340, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL op00_nowrite: got %h expected deadbeef", rsp_rdata); end
        idle();
    endtask

    task automatic test_mcycle_wrap();
        req(12'hB00, 2'd1, 32'hFFFF_FFFF);
        idle();
        req(12'hB80, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'd1) begin n_err++; $display("FAIL mcycleh_carry: got %h expected 1", rsp_rdata); end
        idle();
        req(12'hB00, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'd2) begin n_err++; $display("FAIL mcycle_wrapped: got %h expected 2", rsp_rdata); end
        idle();
    endtask

    task automatic test_trap_mret();
        req(12'h300, 2'd2, 32'd8); idle();
        n_vec++; if (mie_o !== 1'b1) begin n_err++; $display("FAIL mie_set: got %b expected 1", mie_o); end
        step(0, 12'h0, 2'd0, 0, 0, 1, 32'h8000_0103, 32'hB, 32'h55, 0);
        n_vec++; if (mepc_o !== 32'h8000_0100 || mie_o !== 1'b0) begin
            n_err++; $display("FAIL trap_entry: got mepc=%h mie=%b expected 80000100/0", mepc_o, mie_o); end
        req(12'h342, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'hB) begin n_err++; $display("FAIL trap_mcause: got %h expected b", rsp_rdata); end
        idle();
        req(12'h300, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'h0000_1880) begin n_err++; $display("FAIL trap_mstatus: got %h expected 00001880", rsp_rdata); end
        idle();
        step(0, 12'h0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++; if (mie_o !== 1'b1) begin n_err++; $display("FAIL mret_mie: got %b expected 1", mie_o); end
        req(12'h300, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'h0000_1888) begin n_err++; $display("FAIL mret_mstatus: got %h expected 00001888", rsp_rdata); end
        idle();
    endtask

    task automatic test_trap_collision();
        step(1, 12'h341, 2'd1, 32'h1234, 0, 1, 32'h0000_4006, 32'h2, 32'h0, 0);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8000_0100) begin
            n_err++; $display("FAIL collide_rsp: got v=%b d=%h expected v=1 d=80000100", rsp_valid, rsp_rdata); end
        n_vec++; if (mepc_o !== 32'h0000_4004) begin n_err++; $display("FAIL collide_mepc: got %h expected 00004004", mepc_o); end
        idle();
        req(12'h341, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'h0000_4004) begin n_err++; $display("FAIL collide_readback: got %h expected 00004004", rsp_rdata); end
        idle();
    endtask

    task automatic test_reset_in_resp();
        req(12'h340, 2'd1, 32'hA5);
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rir_pre: got %b expected 1", rsp_valid); end
        #2 reset_assert();
        #1;
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL rir_drop: got v=%b r=%b d=%h expected 0/1/0", rsp_valid, req_ready, rsp_rdata); end
        reset_release();
        req(12'hB00, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL cnt_start: got %h expected 0", rsp_rdata); end
        idle();
        req(12'hB00, 2'd2, 32'd0);
        n_vec++; if (rsp_rdata !== 32'd2) begin n_err++; $display("FAIL cnt_third_edge: got %h expected 2", rsp_rdata); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        int unsigned nrsp;
        req(12'h340, 2'd1, 32'hCAFE_0000); idle();
        prev = 32'hCAFE_0000;
        nrsp = 0;
        for (int i = 0; i < 8; i++) begin
            req(12'h340, 2'd1, 32'h1000 + 32'(i));
            n_vec++; if (req_ready !== 1'(i % 2)) begin
                n_err++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, req_ready, 1'(i % 2)); end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                n_vec++; if (rsp_rdata !== prev) begin
                    n_err++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rsp_rdata, prev); end
                prev = 32'h1000 + 32'(i);
            end
        end
        idle();
        n_vec++; if (nrsp != 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", nrsp); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [20];
        logic [31:0] wd;
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                  12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h345, 12'hC00};
        for (int i = 0; i < 3000; i++) begin
            wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 3) != 0, addrs[$urandom_range(0, 19)], 2'($urandom_range(0, 3)),
                 wd, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom,
                 $urandom, $urandom, $urandom_range(0, 19) == 0);
            n_vec++; if (req_ready !== !m_busy || rsp_valid !== m_busy) begin
                n_err++; $display("FAIL rnd_hs[%0d]: got r=%b v=%b expected r=%b v=%b", i, req_ready, rsp_valid, !m_busy, m_busy); end
            if (m_busy) begin
                n_vec++; if (rsp_rdata !== m_rsp_rdata || rsp_illegal !== m_rsp_ill) begin
                    n_err++; $display("FAIL rnd_rsp[%0d] addr=%h: got d=%h i=%b expected d=%h i=%b",
                                      i, req_addr, rsp_rdata, rsp_illegal, m_rsp_rdata, m_rsp_ill); end
            end
            n_vec++; if (trap_vector !== m_mtvec || mepc_o !== m_mepc || mie_o !== m_st_mie) begin
                n_err++; $display("FAIL rnd_state[%0d]: got %h/%h/%b expected %h/%h/%b",
                                  i, trap_vector, mepc_o, mie_o, m_mtvec, m_mepc, m_st_mie); end
        end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1;
        model_reset();
        test_reset();
        test_mcycle_wrap();
        test_rw_rs();
        test_illegal();
        test_trap_mret();
        test_trap_collision();
        test_reset_in_resp();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
